uarc_send_arbiter: RTL and testbench

Registered arbiter that accepts UARC bus `send` requests on behalf of a core. It replaces the combinational send mask and priority encoder with a handshaked, parametrised block. It chooses one requesting bus per transaction, by fixed priority or round robin. It latches that bus's data and interrupt handler address, acknowledges the sender, and hands the result to the core as a valid/ready grant. It also tracks the interrupt-active state and allows only explicit waits while a handler is running.

---
 rtl/uarc_send_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_uarc_send_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uarc_send_arbiter.sv
// ============================================================================
//  Module      : uarc_send_arbiter
//  Description : Registered arbiter for UARC bus send requests. Each
//                transaction picks one requesting bus, either by fixed
//                priority (lowest index) or by round robin. It latches that
//                bus's data and interrupt handler address, pulses a one-cycle
//                ack back to the sender, and presents the result to the core
//                as a valid/ready grant. It also tracks whether an interrupt
//                handler is running. While a handler runs, only explicit
//                waits can be granted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   clock, rising edge
//    reset               in   asynchronous active-high reset
//    receiver_sends      in   [TOTAL_BUSES]             per-bus send request
//    receiver_datas      in   [TOTAL_BUSES*WORD_WIDTH]  per-bus send data
//    receiver_send_acks  out  [TOTAL_BUSES]             one-cycle ack to winner
//    enable_we           in   write enable_value into the interrupt mask
//    enable_value        in   [TOTAL_BUSES]             new interrupt mask
//    addr_we             in   write one handler-address table entry
//    addr_bus            in   [BUS_W]                   entry to write
//    addr_value          in   [PROGRAM_ADDR_WIDTH]      handler address
//    wait_req            in   core is blocked waiting on wait_mask buses
//    wait_mask           in   [TOTAL_BUSES]             buses eligible in a wait
//    grant_valid         out  a grant is held for the core
//    grant_ready         in   core accepts the grant
//    grant_bus           out  [BUS_W]                   granted bus index
//    grant_data          out  [WORD_WIDTH]              latched send data
//    grant_addr          out  [PROGRAM_ADDR_WIDTH]      handler address
//    grant_is_wait       out  1 = wait grant, 0 = interrupt grant
//    interrupt_active    out  an interrupt handler is running
//    irq_return          in   pulse: handler finished
// ============================================================================
`default_nettype none

module uarc_send_arbiter #(
    parameter int WORD_MAG           = 5,
    parameter int TOTAL_BUSES        = 4,
    parameter int PROGRAM_ADDR_WIDTH = 8,
    parameter int ROUND_ROBIN        = 0,
    localparam int WORD_WIDTH        = 1 << WORD_MAG,
    localparam int BUS_W             = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [TOTAL_BUSES-1:0]            receiver_sends,
    input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
    output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
    input  logic                              enable_we,
    input  logic [TOTAL_BUSES-1:0]            enable_value,
    input  logic                              addr_we,
    input  logic [BUS_W-1:0]                  addr_bus,
    input  logic [PROGRAM_ADDR_WIDTH-1:0]     addr_value,
    input  logic                              wait_req,
    input  logic [TOTAL_BUSES-1:0]            wait_mask,
    output logic                              grant_valid,
    input  logic                              grant_ready,
    output logic [BUS_W-1:0]                  grant_bus,
    output logic [WORD_WIDTH-1:0]             grant_data,
    output logic [PROGRAM_ADDR_WIDTH-1:0]     grant_addr,
    output logic                              grant_is_wait,
    output logic                              interrupt_active,
    input  logic                              irq_return
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [BUS_W-1:0] c_LAST_RESET = BUS_W'(TOTAL_BUSES - 1);

    state_t                          r_state;
    logic                            r_valid;
    logic [TOTAL_BUSES-1:0]          r_ack;
    logic [BUS_W-1:0]                r_bus;
    logic [WORD_WIDTH-1:0]           r_data;
    logic [PROGRAM_ADDR_WIDTH-1:0]   r_addr;
    logic                            r_is_wait;
    logic                            r_irq_active;
    logic [TOTAL_BUSES-1:0]          r_enable;
    logic [BUS_W-1:0]                r_last;
    logic [PROGRAM_ADDR_WIDTH-1:0]   r_table [TOTAL_BUSES];

    logic [TOTAL_BUSES-1:0]          w_eligible;
    logic                            w_is_wait;
    logic                            w_found;
    logic [BUS_W-1:0]                w_sel;
    int                              w_idx;
    logic [TOTAL_BUSES-1:0]          w_onehot;
    logic [WORD_WIDTH-1:0]           w_sel_data;
    logic [PROGRAM_ADDR_WIDTH-1:0]   w_sel_addr;
    logic                            w_accept;

    // ------------------------------------------------------------------
    // Eligibility. A wait always takes precedence. Interrupts are only
    // considered while no handler is running. The flag is the registered
    // value, so an irq_return in this cycle does not yet unblock anything.
    // ------------------------------------------------------------------
    always_comb begin
        w_eligible = '0;
        w_is_wait  = 1'b0;
        if (wait_req) begin
            w_eligible = receiver_sends & wait_mask;
            w_is_wait  = 1'b1;
        end else if (!r_irq_active) begin
            w_eligible = receiver_sends & r_enable;
        end
    end

    // ------------------------------------------------------------------
    // Selection. Fixed priority scans from index 0. Round robin scans from
    // last+1 and wraps around. The inner loop compares against a constant
    // index so that no variable-width bit select is needed.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = 0; k < TOTAL_BUSES; k++) begin
            if (ROUND_ROBIN != 0) begin
                w_idx = (int'(r_last) + 1 + k) % TOTAL_BUSES;
            end else begin
                w_idx = k;
            end
            for (int j = 0; j < TOTAL_BUSES; j++) begin
                if (!w_found && (j == w_idx) && w_eligible[j]) begin
                    w_found = 1'b1;
                    w_sel   = BUS_W'(j);
                end
            end
        end
    end

    // Ack vector, data and handler address of the selected bus.
    always_comb begin
        w_onehot   = '0;
        w_sel_data = '0;
        w_sel_addr = '0;
        for (int k = 0; k < TOTAL_BUSES; k++) begin
            if (w_sel == BUS_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_sel_data  = receiver_datas[k*WORD_WIDTH +: WORD_WIDTH];
                w_sel_addr  = r_table[k];
            end
        end
    end

    assign w_accept = (r_state == ST_PENDING) && grant_ready;

    // ------------------------------------------------------------------
    // FSM, grant registers and configuration state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_ack        <= '0;
            r_bus        <= '0;
            r_data       <= '0;
            r_addr       <= '0;
            r_is_wait    <= 1'b0;
            r_irq_active <= 1'b0;
            r_enable     <= '0;
            r_last       <= c_LAST_RESET;
            for (int k = 0; k < TOTAL_BUSES; k++) begin
                r_table[k] <= '0;
            end
        end else begin
            // The ack is a single-cycle pulse issued only on capture.
            r_ack <= '0;

            // Config writes land on this edge. Arbitration in this cycle
            // has already used the old mask and table. An out-of-range
            // addr_bus matches no entry and is dropped.
            if (enable_we) begin
                r_enable <= enable_value;
            end
            for (int k = 0; k < TOTAL_BUSES; k++) begin
                if (addr_we && (addr_bus == BUS_W'(k))) begin
                    r_table[k] <= addr_value;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state   <= ST_PENDING;
                        r_valid   <= 1'b1;
                        r_bus     <= w_sel;
                        r_data    <= w_sel_data;
                        r_addr    <= w_sel_addr;
                        r_is_wait <= w_is_wait;
                        r_ack     <= w_onehot;
                        r_last    <= w_sel;
                    end
                end
                ST_PENDING: begin
                    // Sends are ignored here. The grant fields stay frozen
                    // until the core accepts the grant.
                    if (grant_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase

            // Accepting an interrupt grant starts a handler. If irq_return
            // arrives on the same edge, the set still wins.
            if (w_accept && !r_is_wait) begin
                r_irq_active <= 1'b1;
            end else if (irq_return) begin
                r_irq_active <= 1'b0;
            end
        end
    end

    assign grant_valid        = r_valid;
    assign receiver_send_acks = r_ack;
    assign grant_bus          = r_bus;
    assign grant_data         = r_data;
    assign grant_addr         = r_addr;
    assign grant_is_wait      = r_is_wait;
    assign interrupt_active   = r_irq_active;

endmodule

`default_nettype wire

// File: tb/tb_uarc_send_arbiter.sv
// ============================================================================
//  Module      : tb_uarc_send_arbiter
//  Description : Self-checking bench for uarc_send_arbiter. It runs a fixed-
//                priority instance and a round-robin instance side by side,
//                driving both from the same inputs. Directed scenarios check
//                the values the spec expects. A randomized phase compares
//                both instances against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uarc_send_arbiter;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    sends = '0;
    logic [127:0]  datas = '0;
    logic          enable_we = 1'b0;
    logic [3:0]    enable_value = '0;
    logic          addr_we = 1'b0;
    logic [1:0]    addr_bus = '0;
    logic [7:0]    addr_value = '0;
    logic          wait_req = 1'b0;
    logic [3:0]    wait_mask = '0;
    logic          grant_ready = 1'b0;
    logic          irq_return = 1'b0;

    // Index 0: fixed priority, index 1: round robin
    logic [3:0]    ack_o   [2];
    logic          valid_o [2];
    logic [1:0]    bus_o   [2];
    logic [31:0]   data_o  [2];
    logic [7:0]    addr_o  [2];
    logic          wait_o  [2];
    logic          irq_o   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uarc_send_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(4), .PROGRAM_ADDR_WIDTH(8), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset), .receiver_sends(sends), .receiver_datas(datas),
        .receiver_send_acks(ack_o[0]), .enable_we(enable_we), .enable_value(enable_value),
        .addr_we(addr_we), .addr_bus(addr_bus), .addr_value(addr_value),
        .wait_req(wait_req), .wait_mask(wait_mask), .grant_valid(valid_o[0]),
        .grant_ready(grant_ready), .grant_bus(bus_o[0]), .grant_data(data_o[0]),
        .grant_addr(addr_o[0]), .grant_is_wait(wait_o[0]),
        .interrupt_active(irq_o[0]), .irq_return(irq_return)
    );

    uarc_send_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(4), .PROGRAM_ADDR_WIDTH(8), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset(reset), .receiver_sends(sends), .receiver_datas(datas),
        .receiver_send_acks(ack_o[1]), .enable_we(enable_we), .enable_value(enable_value),
        .addr_we(addr_we), .addr_bus(addr_bus), .addr_value(addr_value),
        .wait_req(wait_req), .wait_mask(wait_mask), .grant_valid(valid_o[1]),
        .grant_ready(grant_ready), .grant_bus(bus_o[1]), .grant_data(data_o[1]),
        .grant_addr(addr_o[1]), .grant_is_wait(wait_o[1]),
        .interrupt_active(irq_o[1]), .irq_return(irq_return)
    );

    // ------------------------------------------------------------------
    // Reference model: one pending transaction per arbiter
    // ------------------------------------------------------------------
    bit          m_valid [2];
    logic [1:0]  m_bus   [2];
    logic [31:0] m_data  [2];
    logic [7:0]  m_addr  [2];
    bit          m_wait  [2];
    logic [3:0]  m_ack   [2];
    bit          m_irq   [2];
    int          m_last  [2];
    logic [3:0]  m_en;
    logic [7:0]  m_tab   [4];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 0; m_bus[p] = 0; m_data[p] = 0; m_addr[p] = 0;
            m_wait[p] = 0; m_ack[p] = 0; m_irq[p] = 0; m_last[p] = 3;
        end
        m_en = 0;
        for (int k = 0; k < 4; k++) m_tab[k] = 0;
    endtask

    // Applies one rising edge using the inputs that stand at that edge.
    task automatic model_clock();
        logic [3:0] elig;
        int sel;
        bit found;
        bit set_irq;
        if (reset) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            m_ack[p] = 0;
            if (m_valid[p]) begin
                set_irq = 0;
                if (grant_ready) begin
                    m_valid[p] = 0;
                    set_irq = !m_wait[p];
                end
                if (set_irq) m_irq[p] = 1;
                else if (irq_return) m_irq[p] = 0;
            end else begin
                if (wait_req) elig = sends & wait_mask;
                else if (!m_irq[p]) elig = sends & m_en;
                else elig = 0;
                found = 0;
                sel = 0;
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (p == 0) ? k : (m_last[p] + 1 + k) % 4;
                    if (!found && elig[idx]) begin
                        found = 1;
                        sel = idx;
                    end
                end
                if (found) begin
                    m_valid[p] = 1;
                    m_bus[p]   = 2'(sel);
                    m_data[p]  = datas[sel*32 +: 32];
                    m_addr[p]  = m_tab[sel];
                    m_wait[p]  = wait_req;
                    m_ack[p]   = 4'(1 << sel);
                    m_last[p]  = sel;
                end
                if (irq_return) m_irq[p] = 0;
            end
        end
        if (enable_we) m_en = enable_value;
        if (addr_we) m_tab[addr_bus] = addr_value;
    endtask

    // One clock: the model follows the edge, and the caller samples on the
    // falling edge.
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if ({valid_o[p], ack_o[p], bus_o[p], data_o[p], addr_o[p], wait_o[p], irq_o[p]} !== 49'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got v=%0b ack=%b bus=%0d data=%h addr=%h w=%0b irq=%0b, want all 0",
                         p, valid_o[p], ack_o[p], bus_o[p], data_o[p], addr_o[p], wait_o[p], irq_o[p]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_fixed_priority();
        enable_we = 1; enable_value = 4'b1111;
        addr_we = 1; addr_bus = 2; addr_value = 8'h40;
        tick();
        enable_we = 0; addr_we = 0;
        sends = 4'b1100;
        datas[2*32 +: 32] = 32'hA5A5_0002;
        datas[3*32 +: 32] = 32'h3333_3333;
        tick();
        n_cmp++;
        if ({valid_o[0], bus_o[0], addr_o[0], data_o[0], ack_o[0], wait_o[0]} !==
            {1'b1, 2'd2, 8'h40, 32'hA5A5_0002, 4'b0100, 1'b0}) begin
            n_fail++;
            $display("FAIL fp_capture: got v=%0b bus=%0d addr=%h data=%h ack=%b w=%0b, want v=1 bus=2 addr=40 data=a5a50002 ack=0100 w=0",
                     valid_o[0], bus_o[0], addr_o[0], data_o[0], ack_o[0], wait_o[0]);
        end
        sends = 0;
        grant_ready = 1;
        tick();
        grant_ready = 0;
        n_cmp++;
        if ({valid_o[0], ack_o[0], irq_o[0]} !== {1'b0, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL fp_accept: got v=%0b ack=%b irq=%0b, want v=0 ack=0000 irq=1",
                     valid_o[0], ack_o[0], irq_o[0]);
        end
    endtask

    task automatic test_handler_blocks();
        sends = 4'b0001;
        tick();
        tick();
        n_cmp++;
        if ({valid_o[0], ack_o[0]} !== 5'b0_0000) begin
            n_fail++;
            $display("FAIL irq_blocks: got v=%0b ack=%b, want v=0 ack=0000", valid_o[0], ack_o[0]);
        end
        wait_req = 1; wait_mask = 4'b0001;
        tick();
        n_cmp++;
        if ({valid_o[0], bus_o[0], wait_o[0], irq_o[0], ack_o[0]} !== {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL wait_grant: got v=%0b bus=%0d w=%0b irq=%0b ack=%b, want v=1 bus=0 w=1 irq=1 ack=0001",
                     valid_o[0], bus_o[0], wait_o[0], irq_o[0], ack_o[0]);
        end
        sends = 0; wait_req = 0; grant_ready = 1;
        tick();
        grant_ready = 0;
        n_cmp++;
        if ({valid_o[0], irq_o[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL wait_accept: got v=%0b irq=%0b, want v=0 irq=1", valid_o[0], irq_o[0]);
        end
        irq_return = 1;
        tick();
        irq_return = 0;
        n_cmp++;
        if (irq_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_return: got irq=%0b, want 0", irq_o[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rr [5];
        exp_rr = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
        reset = 1;
        tick();
        reset = 0;
        wait_req = 1; wait_mask = 4'b1111; sends = 4'b1011; grant_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({valid_o[1], bus_o[1], valid_o[0], bus_o[0]} !== {1'b1, exp_rr[i], 1'b1, 2'd0}) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got rr v=%0b bus=%0d fp v=%0b bus=%0d, want rr v=1 bus=%0d fp v=1 bus=0",
                         i, valid_o[1], bus_o[1], valid_o[0], bus_o[0], exp_rr[i]);
            end
            tick();
            n_cmp++;
            if (valid_o[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: got v=%0b, want 0", i, valid_o[1]);
            end
        end
        sends = 0; wait_req = 0; grant_ready = 0;
    endtask

    task automatic test_backpressure();
        wait_req = 1; wait_mask = 4'b1111; grant_ready = 0;
        sends = 4'b0100;
        datas[2*32 +: 32] = 32'hDEAD_0002;
        tick();
        n_cmp++;
        if ({valid_o[0], bus_o[0], ack_o[0]} !== {1'b1, 2'd2, 4'b0100}) begin
            n_fail++;
            $display("FAIL bp_capture: got v=%0b bus=%0d ack=%b, want v=1 bus=2 ack=0100", valid_o[0], bus_o[0], ack_o[0]);
        end
        sends = 4'b0001;
        datas[2*32 +: 32] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({valid_o[0], bus_o[0], data_o[0], ack_o[0]} !== {1'b1, 2'd2, 32'hDEAD_0002, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%0b bus=%0d data=%h ack=%b, want v=1 bus=2 data=dead0002 ack=0000",
                         i, valid_o[0], bus_o[0], data_o[0], ack_o[0]);
            end
        end
        grant_ready = 1;
        tick();
        grant_ready = 0;
        n_cmp++;
        if ({valid_o[0], ack_o[0]} !== 5'b0_0000) begin
            n_fail++;
            $display("FAIL bp_accept: got v=%0b ack=%b, want v=0 ack=0000", valid_o[0], ack_o[0]);
        end
        tick();
        n_cmp++;
        if ({valid_o[0], bus_o[0], ack_o[0]} !== {1'b1, 2'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL bp_next: got v=%0b bus=%0d ack=%b, want v=1 bus=0 ack=0001", valid_o[0], bus_o[0], ack_o[0]);
        end
        sends = 0; grant_ready = 1;
        tick();
        grant_ready = 0; wait_req = 0;
    endtask

    task automatic test_config_race();
        enable_we = 1; enable_value = 4'b1111;
        tick();
        enable_value = 4'b0000;
        sends = 4'b0010;
        tick();
        enable_we = 0;
        n_cmp++;
        if ({valid_o[0], bus_o[0], wait_o[0], ack_o[0]} !== {1'b1, 2'd1, 1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL race_grant: got v=%0b bus=%0d w=%0b ack=%b, want v=1 bus=1 w=0 ack=0010",
                     valid_o[0], bus_o[0], wait_o[0], ack_o[0]);
        end
        sends = 0; grant_ready = 1;
        tick();
        grant_ready = 0; irq_return = 1;
        tick();
        irq_return = 0;
        sends = 4'b0010;
        tick();
        tick();
        n_cmp++;
        if ({valid_o[0], ack_o[0], irq_o[0]} !== 6'b0_0000_0) begin
            n_fail++;
            $display("FAIL race_masked: got v=%0b ack=%b irq=%0b, want v=0 ack=0000 irq=0", valid_o[0], ack_o[0], irq_o[0]);
        end
        sends = 0;
    endtask

    task automatic test_async_reset();
        enable_we = 1; enable_value = 4'b1111;
        tick();
        enable_we = 0;
        sends = 4'b0001;
        tick();
        sends = 0; grant_ready = 1;
        tick();
        grant_ready = 0;
        wait_req = 1; wait_mask = 4'b0100; sends = 4'b0100;
        tick();
        n_cmp++;
        if ({valid_o[0], ack_o[0], irq_o[0]} !== {1'b1, 4'b0100, 1'b1}) begin
            n_fail++;
            $display("FAIL ar_setup: got v=%0b ack=%b irq=%0b, want v=1 ack=0100 irq=1", valid_o[0], ack_o[0], irq_o[0]);
        end
        #2;
        reset = 1;
        #1;
        model_reset();
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if ({valid_o[p], ack_o[p], irq_o[p]} !== 6'd0) begin
                n_fail++;
                $display("FAIL ar_immediate[%0d]: got v=%0b ack=%b irq=%0b, want all 0", p, valid_o[p], ack_o[p], irq_o[p]);
            end
        end
        tick();
        reset = 0;
        tick();
        n_cmp++;
        if ({valid_o[0], bus_o[0], ack_o[0], wait_o[0]} !== {1'b1, 2'd2, 4'b0100, 1'b1}) begin
            n_fail++;
            $display("FAIL ar_regrant: got v=%0b bus=%0d ack=%b w=%0b, want v=1 bus=2 ack=0100 w=1",
                     valid_o[0], bus_o[0], ack_o[0], wait_o[0]);
        end
        sends = 0; wait_req = 0; grant_ready = 1;
        tick();
        grant_ready = 0;
    endtask

    task automatic test_random();
        reset = 1;
        tick();
        reset = 0;
        for (int c = 0; c < 400; c++) begin
            sends        = 4'($urandom);
            datas        = {$urandom(), $urandom(), $urandom(), $urandom()};
            wait_req     = ($urandom_range(0, 3) == 0);
            wait_mask    = 4'($urandom);
            grant_ready  = ($urandom_range(0, 2) != 0);
            irq_return   = ($urandom_range(0, 7) == 0);
            enable_we    = ($urandom_range(0, 9) == 0);
            enable_value = 4'($urandom);
            addr_we      = ($urandom_range(0, 4) == 0);
            addr_bus     = 2'($urandom);
            addr_value   = 8'($urandom);
            tick();
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if ({valid_o[p], ack_o[p], irq_o[p]} !== {m_valid[p], m_ack[p], m_irq[p]}) begin
                    n_fail++;
                    $display("FAIL rand_ctrl[%0d] cyc %0d: got v=%0b ack=%b irq=%0b, want v=%0b ack=%b irq=%0b",
                             p, c, valid_o[p], ack_o[p], irq_o[p], m_valid[p], m_ack[p], m_irq[p]);
                end
                if (m_valid[p]) begin
                    n_cmp++;
                    if ({bus_o[p], data_o[p], addr_o[p], wait_o[p]} !== {m_bus[p], m_data[p], m_addr[p], m_wait[p]}) begin
                        n_fail++;
                        $display("FAIL rand_grant[%0d] cyc %0d: got bus=%0d data=%h addr=%h w=%0b, want bus=%0d data=%h addr=%h w=%0b",
                                 p, c, bus_o[p], data_o[p], addr_o[p], wait_o[p], m_bus[p], m_data[p], m_addr[p], m_wait[p]);
                    end
                end
            end
        end
        sends = 0; wait_req = 0; grant_ready = 0; irq_return = 0; enable_we = 0; addr_we = 0;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_handler_blocks();
        test_round_robin();
        test_backpressure();
        test_config_race();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
